// File: rtl/stump_lshift_seq.sv
// Multi-cycle left shifter (LSL / ROL / RLC), one bit per clock, with a
// start/busy/done handshake; result and carry hold until the next accepted start.
module stump_lshift_seq #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_A,
    input  logic             c_in,
    input  logic [1:0]       shift_op,
    input  logic [AMT_W-1:0] shift_amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shift_out,
    output logic             c_out
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0]       OP_NONE = 2'b00;
    localparam logic [1:0]       OP_LSL  = 2'b01;
    localparam logic [1:0]       OP_ROL  = 2'b10;
    localparam logic [1:0]       OP_RLC  = 2'b11;
    localparam logic [AMT_W-1:0] CNT_ONE = {{(AMT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic [AMT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic             busy_q, done_q;
    logic             accept;

    // Single-step datapath: every op shifts the MSB into carry.
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        case (op_q)
            OP_LSL: begin r_d = {r_q[WIDTH-2:0], 1'b0};         c_d = r_q[WIDTH-1]; end
            OP_ROL: begin r_d = {r_q[WIDTH-2:0], r_q[WIDTH-1]}; c_d = r_q[WIDTH-1]; end
            OP_RLC: begin r_d = {r_q[WIDTH-2:0], c_q};          c_d = r_q[WIDTH-1]; end
            default: ;
        endcase
    end

    assign accept = start && (state_q != S_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    r_q   <= r_d;
                    c_q   <= c_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        r_q   <= operand_A;
                        c_q   <= c_in;
                        op_q  <= shift_op;
                        cnt_q <= shift_amt;
                        // Zero amount or no-op completes immediately as a passthrough.
                        if (shift_amt == '0 || shift_op == OP_NONE) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign shift_out = r_q;
    assign c_out     = c_q;
endmodule

// File: tb/tb_stump_lshift_seq.sv
// Directed bench for stump_lshift_seq: vector table plus hand-written
// sequences for ignored start, back-to-back start, intermediate state and reset abort.
module tb_stump_lshift_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] operand_A;
    logic        c_in;
    logic [1:0]  shift_op;
    logic [3:0]  shift_amt;
    logic        busy, done;
    logic [15:0] shift_out;
    logic        c_out;

    int vectors = 0;
    int fails   = 0;

    stump_lshift_seq #(.WIDTH(16), .AMT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .operand_A(operand_A), .c_in(c_in),
        .shift_op(shift_op), .shift_amt(shift_amt), .busy(busy), .done(done),
        .shift_out(shift_out), .c_out(c_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic        cin;
        logic [3:0]  amt;
        logic [15:0] exp_out;
        logic        exp_c;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request so that the next rising edge (E0) accepts it.
    task automatic launch(input logic [1:0] op, input logic [15:0] a, input logic cin,
                          input logic [3:0] amt);
        @(negedge clk);
        shift_op = op; operand_A = a; c_in = cin; shift_amt = amt; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Index 0 is the cycle after the most recent edge; lat = -1 if done never seen.
    task automatic wait_done(input int budget, output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, bc;
        rst = 1'b1; start = 1'b0; operand_A = '0; c_in = 1'b0; shift_op = 2'b00; shift_amt = '0;

        vecs[0] = '{2'b01, 16'h8001, 1'b0, 4'd1,  16'h0002, 1'b1, 1};
        vecs[1] = '{2'b10, 16'h8001, 1'b0, 4'd4,  16'h0018, 1'b0, 4};
        vecs[2] = '{2'b11, 16'h4000, 1'b1, 4'd2,  16'h0002, 1'b1, 2};
        vecs[3] = '{2'b00, 16'h1234, 1'b1, 4'd7,  16'h1234, 1'b1, 0};
        vecs[4] = '{2'b01, 16'hABCD, 1'b0, 4'd0,  16'hABCD, 1'b0, 0};
        vecs[5] = '{2'b01, 16'hFFFF, 1'b0, 4'd15, 16'h8000, 1'b1, 15};
        vecs[6] = '{2'b10, 16'h8001, 1'b1, 4'd15, 16'hC000, 1'b0, 15};
        vecs[7] = '{2'b11, 16'h0000, 1'b1, 4'd15, 16'h4000, 1'b0, 15};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_out",  32'(shift_out), 0);
        check("reset_c",    32'(c_out), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].cin, vecs[i].amt);
            wait_done(40, lat, bc);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_out", i), 32'(shift_out), 32'(vecs[i].exp_out));
            check($sformatf("v%0d_cout", i), 32'(c_out), 32'(vecs[i].exp_c));
            @(negedge clk);
            check($sformatf("v%0d_done_single", i), 32'(done), 0);
            check($sformatf("v%0d_out_hold", i), 32'(shift_out), 32'(vecs[i].exp_out));
        end

        // RLC intermediate: after the first step R=0x8001, C=0.
        launch(2'b11, 16'h4000, 1'b1, 4'd2);
        @(negedge clk);
        @(negedge clk);
        check("rlc_mid_out",  32'(shift_out), 32'h8001);
        check("rlc_mid_c",    32'(c_out), 0);
        check("rlc_mid_busy", 32'(busy), 1);
        wait_done(5, lat, bc);
        check("rlc_mid_latency", 32'(lat), 0);
        check("rlc_mid_final", 32'(shift_out), 32'h0002);

        // Start pulsed at E3 is ignored; start held in DONE is accepted back-to-back.
        launch(2'b01, 16'hFFFF, 1'b0, 4'd15);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        shift_op = 2'b10; operand_A = 16'h1234; c_in = 1'b1; shift_amt = 4'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        operand_A = 16'h5555; shift_op = 2'b11;
        wait_done(40, lat, bc);
        check("ign_latency", 32'(lat), 12);
        check("ign_busy",    32'(bc), 12);
        check("ign_out",     32'(shift_out), 32'h8000);
        check("ign_cout",    32'(c_out), 1);
        shift_op = 2'b10; operand_A = 16'h8001; c_in = 1'b0; shift_amt = 4'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(40, lat, bc);
        check("b2b_latency", 32'(lat), 4);
        check("b2b_busy",    32'(bc), 4);
        check("b2b_out",     32'(shift_out), 32'h0018);
        check("b2b_cout",    32'(c_out), 0);

        // Reset at E5 aborts a 15-step LSL with no done pulse.
        launch(2'b01, 16'hFFFF, 1'b0, 4'd15);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_out",  32'(shift_out), 0);
        check("abort_c",    32'(c_out), 0);
        rst = 1'b0;
        wait_done(20, lat, bc);
        check("abort_no_done", 32'(lat), 32'hFFFF_FFFF);
        check("abort_idle",    32'(bc), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
